// File: rtl/pd_trace_streamer.sv
// pd_trace_streamer: buffers one record per retired instruction and streams it as four 32-bit words,
// then detects end of program, drains, emits a trailer word and raises done.
module pd_trace_streamer #(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] SP_TOP       = 32'h01100000,
  parameter int          TAIL_RECORDS = 3,
  parameter int          MAX_RECORDS  = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic [31:0] retire_insn,
  input  logic        retire_wen,
  input  logic [4:0]  retire_rd,
  input  logic [31:0] retire_wdata,
  input  logic [31:0] sp_value,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic        done,
  output logic [1:0]  exit_code,
  output logic        overflow,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RECORDS + 1) > 17 ? $clog2(MAX_RECORDS + 1) : 17;
  typedef enum logic [2:0] {RUN, TAIL, DRAIN, TRAILER, FIN} state_t;
  state_t state, state_n;
  logic [1:0] code_n;
  logic [101:0] mem [DEPTH];
  logic [101:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] widx;
  logic [RW-1:0] rec_cnt;
  logic [15:0] tail_cnt;
  logic sp_armed, capture, ecall, timeout, hs, pop, push;
  assign capture = retire_valid && (state == RUN || state == TAIL);
  assign ecall = retire_insn[6:0] == 7'h73;
  assign timeout = capture && rec_cnt == RW'(MAX_RECORDS - 1);
  assign hs = tx_valid && tx_ready;
  assign pop = hs && state != TRAILER && widx == 2'd3;
  // a full FIFO still accepts when the head record leaves in the same cycle
  assign push = capture && (count != (AW+1)'(DEPTH) || pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      exit_code <= '0;
      sp_armed <= 1'b0;
      tail_cnt <= '0;
      rec_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      widx <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      exit_code <= code_n;
      if (state == RUN && sp_value < SP_TOP) sp_armed <= 1'b1;
      if (state == RUN && capture && ecall) tail_cnt <= 16'(TAIL_RECORDS);
      else if (state == TAIL && capture) tail_cnt <= tail_cnt - 16'd1;
      if (capture && rec_cnt != RW'(MAX_RECORDS)) rec_cnt <= rec_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (hs && state != TRAILER) widx <= widx + 2'd1;
      if (capture && !push) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end
  always_ff @(posedge clock) if (push) mem[wr_ptr] <= {retire_pc, retire_insn, retire_wen, retire_rd, retire_wdata};
  always_comb begin
    state_n = state;
    code_n = exit_code;
    case (state)
      RUN:
        if (capture && ecall) begin
          code_n = 2'd1;
          state_n = TAIL_RECORDS > 0 ? TAIL : DRAIN;
        end else if (sp_armed && sp_value == SP_TOP) begin
          code_n = 2'd2;
          state_n = DRAIN;
        end else if (timeout) begin
          code_n = 2'd3;
          state_n = DRAIN;
        end
      TAIL: if (timeout || (capture && tail_cnt == 16'd1)) state_n = DRAIN;
      DRAIN: if (count == '0) state_n = TRAILER;
      TRAILER: if (tx_ready) state_n = FIN;
      default: ;
    endcase
  end
  always_comb begin
    tx_valid = state == TRAILER || count != '0;
    tx_last = state == TRAILER || (count != '0 && widx == 2'd3);
    tx_data = state == TRAILER ? {16'hE0F0, 14'b0, exit_code} :
              count == '0 ? '0 :
              widx == 2'd0 ? head[101:70] :
              widx == 2'd1 ? head[69:38] :
              widx == 2'd2 ? {head[37], 26'b0, head[36:32]} : head[31:0];
    done = state == FIN;
  end
endmodule

// File: tb/tb_pd_trace_streamer.sv
// tb_pd_trace_streamer: directed scenarios for pd_trace_streamer with hand-computed expectations.
module tb_pd_trace_streamer;
  logic clk = 1'b0, rst = 1'b0;
  logic retire_valid = 1'b0, retire_wen = 1'b0, tx_ready = 1'b0;
  logic [31:0] retire_pc = '0, retire_insn = '0, retire_wdata = '0, sp_value = 32'h01100000;
  logic [4:0] retire_rd = '0;
  logic tx_valid, tx_last, done, overflow;
  logic [31:0] tx_data;
  logic [1:0] exit_code;
  logic [15:0] drop_count;
  int checks = 0, passed = 0;
  logic [31:0] wq[$];
  logic lq[$];

  pd_trace_streamer dut (
    .clock(clk), .reset(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_insn(retire_insn), .retire_wen(retire_wen), .retire_rd(retire_rd),
    .retire_wdata(retire_wdata), .sp_value(sp_value), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .done(done), .exit_code(exit_code),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && tx_valid && tx_ready) begin
      wq.push_back(tx_data);
      lq.push_back(tx_last);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    retire_valid = 1'b0;
    sp_value = 32'h01100000;
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
    lq.delete();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic wen,
                        input logic [4:0] rd, input logic [31:0] wdata);
    retire_valid = 1'b1;
    retire_pc = pc;
    retire_insn = insn;
    retire_wen = wen;
    retire_rd = rd;
    retire_wdata = wdata;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0h want 0", tx_valid); else passed++;
    checks++; if (tx_data !== 32'h0) $display("FAIL reset_tx_data got %h want 0", tx_data); else passed++;
    checks++; if (tx_last !== 1'b0) $display("FAIL reset_tx_last got %0h want 0", tx_last); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0h want 0", done); else passed++;
    checks++; if (exit_code !== 2'd0) $display("FAIL reset_exit_code got %0d want 0", exit_code); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0h want 0", overflow); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count got %0d want 0", drop_count); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) retire(32'h100 + 32'(4 * i), 32'h00500293, 1'b1, 5'd5, 32'h10 + 32'(i));
    for (int k = 0; k < 100 && wq.size() < 20; k++) tick();
    checks++; if (wq.size() != 20) $display("FAIL stream_count got %0d want 20", wq.size()); else passed++;
    for (int i = 0; i < 20 && i < wq.size(); i++) begin
      exp = i % 4 == 0 ? 32'h100 + 32'(4 * (i / 4)) : i % 4 == 1 ? 32'h00500293 :
            i % 4 == 2 ? 32'h80000005 : 32'h10 + 32'(i / 4);
      checks++; if (wq[i] !== exp) $display("FAIL stream_word[%0d] got %h want %h", i, wq[i], exp); else passed++;
      checks++; if (lq[i] !== (i % 4 == 3)) $display("FAIL stream_last[%0d] got %0h want %0h", i, lq[i], i % 4 == 3); else passed++;
    end
    checks++; if (overflow !== 1'b0) $display("FAIL stream_overflow got %0h want 0", overflow); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    tx_ready = 1'b0;
    retire(32'h1234, 32'h00A00313, 1'b1, 5'd6, 32'hCAFE);
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h80000006 || tx_last !== 1'b0)
        $display("FAIL stall_hold[%0d] got v=%0h d=%h l=%0h want v=1 d=80000006 l=0", k, tx_valid, tx_data, tx_last);
      else passed++;
      tick();
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && wq.size() < 4; k++) tick();
    tick();
    checks++; if (wq.size() != 4) $display("FAIL stall_count got %0d want 4", wq.size()); else passed++;
    if (wq.size() == 4) begin
      checks++; if (wq[0] !== 32'h1234 || wq[1] !== 32'h00A00313 || wq[2] !== 32'h80000006 || wq[3] !== 32'hCAFE)
        $display("FAIL stall_words got %h %h %h %h want 00001234 00a00313 80000006 0000cafe", wq[0], wq[1], wq[2], wq[3]);
      else passed++;
      checks++; if (lq[3] !== 1'b1) $display("FAIL stall_last got %0h want 1", lq[3]); else passed++;
    end
  endtask

  task automatic test_ecall();
    do_reset();
    tx_ready = 1'b1;
    retire(32'h200, 32'h00000073, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) retire(32'h204 + 32'(4 * i), 32'h00000013, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 200 && !done; k++) tick();
    checks++; if (done !== 1'b1) $display("FAIL ecall_done got %0h want 1", done); else passed++;
    checks++; if (exit_code !== 2'd1) $display("FAIL ecall_exit_code got %0d want 1", exit_code); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL ecall_tx_valid_after_done got %0h want 0", tx_valid); else passed++;
    checks++; if (wq.size() != 17) $display("FAIL ecall_count got %0d want 17", wq.size()); else passed++;
    if (wq.size() == 17) begin
      for (int r = 0; r < 4; r++) begin
        checks++; if (wq[4 * r] !== 32'h200 + 32'(4 * r)) $display("FAIL ecall_pc[%0d] got %h want %h", r, wq[4 * r], 32'h200 + 32'(4 * r)); else passed++;
      end
      checks++; if (wq[16] !== 32'hE0F00001 || lq[16] !== 1'b1) $display("FAIL ecall_trailer got %h last=%0h want e0f00001 last=1", wq[16], lq[16]); else passed++;
    end
  endtask

  task automatic test_sp();
    do_reset();
    tx_ready = 1'b1;
    retire(32'h300, 32'h00000013, 1'b0, 5'd0, 32'h0);
    sp_value = 32'h010FFFF0;
    retire(32'h304, 32'h00000013, 1'b0, 5'd0, 32'h0);
    sp_value = 32'h01100000;
    tick();
    retire(32'h30C, 32'h00000013, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 200 && !done; k++) tick();
    checks++; if (done !== 1'b1) $display("FAIL sp_done got %0h want 1", done); else passed++;
    checks++; if (exit_code !== 2'd2) $display("FAIL sp_exit_code got %0d want 2", exit_code); else passed++;
    checks++; if (wq.size() != 9) $display("FAIL sp_count got %0d want 9", wq.size()); else passed++;
    if (wq.size() == 9) begin
      checks++; if (wq[0] !== 32'h300 || wq[4] !== 32'h304) $display("FAIL sp_pcs got %h %h want 00000300 00000304", wq[0], wq[4]); else passed++;
      checks++; if (wq[8] !== 32'hE0F00002) $display("FAIL sp_trailer got %h want e0f00002", wq[8]); else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) retire(32'h400 + 32'(4 * i), 32'h00000013, 1'b1, 5'd1, 32'(i));
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0h want 1", overflow); else passed++;
    checks++; if (drop_count !== 16'd4) $display("FAIL ovf_drop_count got %0d want 4", drop_count); else passed++;
    tx_ready = 1'b1;
    for (int k = 0; k < 200 && wq.size() < 64; k++) tick();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (wq.size() != 64) $display("FAIL ovf_count got %0d want 64", wq.size()); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("FAIL ovf_drained got %0h want 0", tx_valid); else passed++;
    if (wq.size() == 64)
      for (int r = 0; r < 16; r++) begin
        checks++; if (wq[4 * r] !== 32'h400 + 32'(4 * r) || wq[4 * r + 3] !== 32'(r))
          $display("FAIL ovf_order[%0d] got pc=%h wd=%h want pc=%h wd=%h", r, wq[4 * r], wq[4 * r + 3], 32'h400 + 32'(4 * r), 32'(r));
        else passed++;
      end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    retire(32'h500, 32'h00000013, 1'b1, 5'd7, 32'hAA);
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    checks++; if (tx_data !== 32'h80000007) $display("FAIL rmid_w2 got %h want 80000007", tx_data); else passed++;
    rst = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0 || tx_last !== 1'b0)
      $display("FAIL rmid_tx got v=%0h d=%h l=%0h want v=0 d=0 l=0", tx_valid, tx_data, tx_last);
    else passed++;
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0) $display("FAIL rmid_ovf got %0h/%0d want 0/0", overflow, drop_count); else passed++;
    checks++; if (done !== 1'b0 || exit_code !== 2'd0) $display("FAIL rmid_done got %0h/%0d want 0/0", done, exit_code); else passed++;
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    checks++; if (tx_valid !== 1'b0) $display("FAIL rmid_no_residue got %0h want 0", tx_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_ecall();
    test_sp();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
